// File: rtl/wide_par_fifo.sv
// Circular FIFO, PAR_WRITE words in, PAR_READ words out per beat.
// First-word-fall-through head, occupancy flags, sticky error flags.
module wide_par_fifo #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int PAR_WRITE  = 2,
  parameter int PAR_READ   = 1,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           wen,
  input  logic [PAR_WRITE*DATA_WIDTH-1:0] din,
  input  logic                           ren,
  output logic [PAR_READ*DATA_WIDTH-1:0] dout,
  output logic                           ready,
  output logic                           valid,
  output logic                           full,
  output logic                           empty,
  output logic                           almost_full,
  output logic                           almost_empty,
  output logic [ADDR_WIDTH:0]            level,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] PW_L    = LW'(PAR_WRITE);
  localparam logic [LW-1:0] PR_L    = LW'(PAR_READ);
  localparam logic [LW-1:0] AF_L    = LW'(DEPTH - AF_MARGIN);
  localparam logic [LW-1:0] AE_L    = LW'(AE_MARGIN);

  localparam logic [ADDR_WIDTH-1:0] PW_A = ADDR_WIDTH'(PAR_WRITE);
  localparam logic [ADDR_WIDTH-1:0] PR_A = ADDR_WIDTH'(PAR_READ);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [LW-1:0]         lvl;
  logic [LW-1:0]         free;
  logic                  wacc;
  logic                  racc;
  logic                  flush;

  assign free  = DEPTH_L - lvl;
  assign ready = free >= PW_L;
  assign valid = lvl >= PR_L;
  assign full  = lvl == DEPTH_L;
  assign empty = lvl == '0;

  assign almost_full  = lvl >= AF_L;
  assign almost_empty = lvl <= AE_L;
  assign level        = lvl;

  assign flush = rst | clear;
  assign wacc  = wen & ready;
  assign racc  = ren & valid;

  // Storage is never reset; only pointers and level are.
  always_ff @(posedge clk) begin
    if (!flush && wacc) begin
      for (int i = 0; i < PAR_WRITE; i++) begin
        mem[wptr + ADDR_WIDTH'(i)] <=
          din[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      lvl       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wacc) wptr <= wptr + PW_A;
      if (racc) rptr <= rptr + PR_A;
      lvl <= lvl
           + (wacc ? PW_L : '0)
           - (racc ? PR_L : '0);
      if (wen && !ready) overflow  <= 1'b1;
      if (ren && !valid) underflow <= 1'b1;
    end
  end

  always_comb begin
    dout = '0;
    for (int j = 0; j < PAR_READ; j++) begin
      dout[j*DATA_WIDTH +: DATA_WIDTH] =
        mem[rptr + ADDR_WIDTH'(j)];
    end
  end

endmodule

// File: tb/tb_wide_par_fifo.sv
// Bench for wide_par_fifo: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_wide_par_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        wen;
  logic [15:0] din;
  logic        ren;
  logic [7:0]  dout;
  logic        ready;
  logic        valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  level;
  logic        overflow;
  logic        underflow;

  wide_par_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .wen          (wen),
    .din          (din),
    .ren          (ren),
    .dout         (dout),
    .ready        (ready),
    .valid        (valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q[$];
  logic       m_ovf;
  logic       m_unf;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("level", 32'(level), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == 8));
    chk("ready", 32'(ready), 32'((8 - sz) >= 2));
    chk("valid", 32'(valid), 32'(sz >= 1));
    chk("afull", 32'(almost_full), 32'(sz >= 7));
    chk("aempty", 32'(almost_empty), 32'(sz <= 1));
    chk("ovf", 32'(overflow), 32'(m_ovf));
    chk("unf", 32'(underflow), 32'(m_unf));
    if (sz > 0) chk("dout", 32'(dout), 32'(q[0]));
  endtask

  task automatic step(
    input logic        r,
    input logic        c,
    input logic        w,
    input logic [15:0] d,
    input logic        rd
  );
    bit can_w;
    bit can_r;
    rst   = r;
    clear = c;
    wen   = w;
    din   = d;
    ren   = rd;
    can_w = (8 - q.size()) >= 2;
    can_r = q.size() >= 1;
    @(posedge clk);
    if (r || c) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (rd && can_r) void'(q.pop_front());
      if (w && can_w) begin
        q.push_back(d[7:0]);
        q.push_back(d[15:8]);
      end
      if (w && !can_w) m_ovf = 1'b1;
      if (rd && !can_r) m_unf = 1'b1;
    end
    #1;
    check_all();
    rst   = 1'b0;
    clear = 1'b0;
    wen   = 1'b0;
    ren   = 1'b0;
  endtask

  task automatic wr(input logic [15:0] d);
    step(1'b0, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  initial begin
    m_ovf = 1'b0;
    m_unf = 1'b0;
    rst = 1'b0; clear = 1'b0;
    wen = 1'b0; ren = 1'b0; din = '0;

    // reset
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);

    // ordering
    wr(16'h0201);
    chk("ord_dout0", 32'(dout), 32'h01);
    rd();
    chk("ord_dout1", 32'(dout), 32'h02);
    rd();
    chk("ord_empty", 32'(empty), 32'd1);

    // fill, overflow, drain
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    wr(16'h0201); wr(16'h0403);
    wr(16'h0605); wr(16'h0807);
    chk("fill_full", 32'(full), 32'd1);
    wr(16'hAAAA);
    chk("fill_ovf", 32'(overflow), 32'd1);
    chk("fill_lvl", 32'(level), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_seq", 32'(dout), 32'(i));
      rd();
    end

    // simultaneous access and wrap
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    wr(16'h1110); wr(16'h1312);
    wr(16'h1514); wr(16'h1716);
    for (int i = 0; i < 6; i++) rd();
    wr(16'h1918); wr(16'h1B1A);
    chk("sim_pre", 32'(level), 32'd6);
    step(1'b0, 1'b0, 1'b1, 16'h1D1C, 1'b1);
    chk("sim_lvl", 32'(level), 32'd7);
    rd(); rd(); rd();
    wr(16'h1F1E);
    while (q.size() > 0) rd();

    // underflow and clear
    rd();
    chk("unf_set", 32'(underflow), 32'd1);
    step(1'b0, 1'b1, 1'b1, 16'h3333, 1'b0);
    chk("clr_unf", 32'(underflow), 32'd0);
    chk("clr_lvl", 32'(level), 32'd0);

    // mid-operation reset
    wr(16'h0A09); wr(16'h0C0B); wr(16'h0E0D);
    rd();
    step(1'b1, 1'b0, 1'b1, 16'h5555, 1'b1);
    chk("mrst_lvl", 32'(level), 32'd0);
    wr(16'h2211);
    chk("mrst_dout", 32'(dout), 32'h11);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      step(
        1'($urandom_range(0, 59) == 0),
        1'($urandom_range(0, 39) == 0),
        1'($urandom_range(0, 1)),
        16'($urandom),
        1'($urandom_range(0, 2) != 0)
      );
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
